// File: rtl/ledda_cfg_sequencer.sv
// ledda_cfg_sequencer
// Command-driven write sequencer for the SB_LEDDA_IP register bus. Each
// accepted command is turned into a burst of single-cycle register writes,
// followed by a one-cycle FINISH that raises LEDDEXE and pulses done.
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only in IDLE; cmd_valid may be
// held high for back-to-back commands, one command per sequence.
//
// Ports:
//   clk, rst_n            clock (also LEDDCLK), async active-low reset
//   cmd_valid/cmd_ready   command handshake
//   cmd_full              1 = write all 9 registers, 0 = PWM registers only
//   cmd_breathe           enables the breathe ramp registers
//   cmd_on_time/off_time  LEDDONR / LEDDOFR values
//   cmd_pwm_r/g/b         LEDDPWRR / LEDDPWRG / LEDDPWRB values
//   busy, done            sequence in progress / one-cycle completion pulse
//   ledd_cs, ledd_den, ledd_exe, ledd_addr, ledd_dat   to the LEDDA IP
module ledda_cfg_sequencer #(
    parameter logic [7:0] CR0_VAL  = 8'hD6,
    parameter logic [7:0] BR_VAL   = 8'hED,
    parameter logic [7:0] BCRR_VAL = 8'hE3,
    parameter logic [7:0] BCFR_VAL = 8'hA3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_full,
    input  logic       cmd_breathe,
    input  logic [7:0] cmd_on_time,
    input  logic [7:0] cmd_off_time,
    input  logic [7:0] cmd_pwm_r,
    input  logic [7:0] cmd_pwm_g,
    input  logic [7:0] cmd_pwm_b,
    output logic       busy,
    output logic       done,
    output logic       ledd_cs,
    output logic       ledd_den,
    output logic       ledd_exe,
    output logic [3:0] ledd_addr,
    output logic [7:0] ledd_dat
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Index of the first PWM entry; PWM-only commands start the walk here.
    localparam logic [3:0] PWM_START = 4'd6;
    localparam logic [3:0] LAST_IDX  = 4'd8;

    state_t     state, state_nx;
    logic       cfg_ok, cfg_ok_nx;
    logic [3:0] idx, idx_nx;
    logic [3:0] start_idx;

    logic       breathe_q;
    logic [7:0] on_q, off_q, r_q, g_q, b_q;

    logic       cs_nx, den_nx, exe_nx, busy_nx, done_nx;
    logic [3:0] addr_nx;
    logic [7:0] dat_nx;

    // Write table in bus order: {addr, data} for entry i.
    function automatic logic [11:0] entry(
        input logic [3:0] i,
        input logic       br,
        input logic [7:0] on,
        input logic [7:0] off,
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b
    );
        case (i)
            4'd0:    entry = {4'h8, CR0_VAL};
            4'd1:    entry = {4'h9, BR_VAL};
            4'd2:    entry = {4'hA, on};
            4'd3:    entry = {4'hB, off};
            4'd4:    entry = {4'h5, (br ? BCRR_VAL : 8'h00)};
            4'd5:    entry = {4'h6, (br ? BCFR_VAL : 8'h00)};
            4'd6:    entry = {4'h1, r};
            4'd7:    entry = {4'h2, g};
            default: entry = {4'h3, b};
        endcase
    endfunction

    assign cmd_ready = (state == IDLE);

    // Until one sequence has completed, the IP holds no valid setup, so
    // every command is promoted to a full write.
    assign start_idx = (cmd_full || !cfg_ok) ? 4'd0 : PWM_START;

    always_comb begin
        state_nx  = state;
        idx_nx    = idx;
        cfg_ok_nx = cfg_ok;
        cs_nx     = 1'b0;
        den_nx    = 1'b0;
        exe_nx    = ledd_exe;
        busy_nx   = 1'b0;
        done_nx   = 1'b0;
        addr_nx   = ledd_addr;
        dat_nx    = ledd_dat;
        case (state)
            IDLE: begin
                exe_nx = cfg_ok;
                if (cmd_valid) begin
                    // First write is presented on the accepting edge, so it
                    // is taken from the live command fields.
                    state_nx = WRITE;
                    idx_nx   = start_idx;
                    {addr_nx, dat_nx} = entry(start_idx, cmd_breathe, cmd_on_time,
                                              cmd_off_time, cmd_pwm_r, cmd_pwm_g,
                                              cmd_pwm_b);
                    cs_nx   = 1'b1;
                    den_nx  = 1'b1;
                    exe_nx  = 1'b0;
                    busy_nx = 1'b1;
                end
            end
            WRITE: begin
                busy_nx = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nx = FINISH;
                    exe_nx   = 1'b1;
                    done_nx  = 1'b1;
                end else begin
                    idx_nx = idx + 4'd1;
                    {addr_nx, dat_nx} = entry(idx + 4'd1, breathe_q, on_q, off_q,
                                              r_q, g_q, b_q);
                    cs_nx  = 1'b1;
                    den_nx = 1'b1;
                    exe_nx = 1'b0;
                end
            end
            FINISH: begin
                state_nx  = IDLE;
                cfg_ok_nx = 1'b1;
                exe_nx    = 1'b1;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cfg_ok    <= 1'b0;
            idx       <= 4'd0;
            ledd_cs   <= 1'b0;
            ledd_den  <= 1'b0;
            ledd_exe  <= 1'b0;
            ledd_addr <= 4'h0;
            ledd_dat  <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            cfg_ok    <= cfg_ok_nx;
            idx       <= idx_nx;
            ledd_cs   <= cs_nx;
            ledd_den  <= den_nx;
            ledd_exe  <= exe_nx;
            ledd_addr <= addr_nx;
            ledd_dat  <= dat_nx;
            busy      <= busy_nx;
            done      <= done_nx;
        end
    end

    // Captured command copy; inputs are ignored once the sequence starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            breathe_q <= 1'b0;
            on_q      <= 8'h00;
            off_q     <= 8'h00;
            r_q       <= 8'h00;
            g_q       <= 8'h00;
            b_q       <= 8'h00;
        end else if (state == IDLE && cmd_valid) begin
            breathe_q <= cmd_breathe;
            on_q      <= cmd_on_time;
            off_q     <= cmd_off_time;
            r_q       <= cmd_pwm_r;
            g_q       <= cmd_pwm_g;
            b_q       <= cmd_pwm_b;
        end
    end

endmodule

// File: tb/tb_ledda_cfg_sequencer.sv
// Testbench for ledda_cfg_sequencer. The reference model expands each
// accepted command into the list of {addr, data} writes it must produce.
module tb_ledda_cfg_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_full = 1'b0;
    logic       cmd_breathe = 1'b0;
    logic [7:0] cmd_on_time = 8'h00;
    logic [7:0] cmd_off_time = 8'h00;
    logic [7:0] cmd_pwm_r = 8'h00;
    logic [7:0] cmd_pwm_g = 8'h00;
    logic [7:0] cmd_pwm_b = 8'h00;
    logic       busy, done, ledd_cs, ledd_den, ledd_exe;
    logic [3:0] ledd_addr;
    logic [7:0] ledd_dat;

    always #5 clk = ~clk;

    ledda_cfg_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_full     (cmd_full),
        .cmd_breathe  (cmd_breathe),
        .cmd_on_time  (cmd_on_time),
        .cmd_off_time (cmd_off_time),
        .cmd_pwm_r    (cmd_pwm_r),
        .cmd_pwm_g    (cmd_pwm_g),
        .cmd_pwm_b    (cmd_pwm_b),
        .busy         (busy),
        .done         (done),
        .ledd_cs      (ledd_cs),
        .ledd_den     (ledd_den),
        .ledd_exe     (ledd_exe),
        .ledd_addr    (ledd_addr),
        .ledd_dat     (ledd_dat)
    );

    int n_cmp = 0;
    int n_fail = 0;

    logic [11:0] exp_q[$];
    bit          model_cfg_ok = 1'b0;

    // Per-cycle records; ctl = {ready, busy, done, cs, den, exe}.
    logic [11:0] rec_wr[1:16];
    logic [5:0]  rec_ctl[1:16];

    localparam logic [5:0] CTL_WRITE  = 6'b010110;
    localparam logic [5:0] CTL_FINISH = 6'b011001;
    localparam logic [5:0] CTL_READY  = 6'b100001;
    localparam logic [5:0] CTL_RESET  = 6'b100000;

    function automatic logic [7:0] pick8();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom_range(0, 255));
        endcase
    endfunction

    // Expands one accepted command into its expected writes.
    function automatic void model_cmd(input bit full, input bit breathe,
                                      input logic [7:0] on, input logic [7:0] off,
                                      input logic [7:0] r, input logic [7:0] g,
                                      input logic [7:0] b);
        logic [11:0] seq[9];
        int first;
        seq = '{{4'h8, 8'hD6}, {4'h9, 8'hED}, {4'hA, on}, {4'hB, off},
                {4'h5, (breathe ? 8'hE3 : 8'h00)}, {4'h6, (breathe ? 8'hA3 : 8'h00)},
                {4'h1, r}, {4'h2, g}, {4'h3, b}};
        first = (full || !model_cfg_ok) ? 0 : 6;
        for (int i = first; i < 9; i++) exp_q.push_back(seq[i]);
    endfunction

    task automatic scramble();
        cmd_full     = 1'($urandom_range(0, 1));
        cmd_breathe  = 1'($urandom_range(0, 1));
        cmd_on_time  = 8'($urandom_range(0, 255));
        cmd_off_time = 8'($urandom_range(0, 255));
        cmd_pwm_r    = 8'($urandom_range(0, 255));
        cmd_pwm_g    = 8'($urandom_range(0, 255));
        cmd_pwm_b    = 8'($urandom_range(0, 255));
    endtask

    // Presents one command (called at a falling edge), drops valid after the
    // accepting edge, keeps changing the fields, and records n cycles.
    task automatic send_capture(input bit full, input bit breathe,
                                input logic [7:0] on, input logic [7:0] off,
                                input logic [7:0] r, input logic [7:0] g,
                                input logic [7:0] b, input int n);
        cmd_valid = 1'b1;  cmd_full = full;  cmd_breathe = breathe;
        cmd_on_time = on;  cmd_off_time = off;
        cmd_pwm_r = r;     cmd_pwm_g = g;    cmd_pwm_b = b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        scramble();
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            rec_wr[k]  = {ledd_addr, ledd_dat};
            rec_ctl[k] = {cmd_ready, busy, done, ledd_cs, ledd_den, ledd_exe};
            scramble();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_cfg_ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({cmd_ready, busy, done, ledd_cs, ledd_den, ledd_exe} !== CTL_RESET ||
                {ledd_addr, ledd_dat} !== 12'h000) begin
                n_fail++;
                $display("FAIL reset_idle[%0d]: ctl=%b addr:dat=%h, want ctl=%b addr:dat=000",
                         c, {cmd_ready, busy, done, ledd_cs, ledd_den, ledd_exe},
                         {ledd_addr, ledd_dat}, CTL_RESET);
            end
        end
    endtask

    // Fixed directed commands first, then randomized ones with 00/FF bias.
    task automatic test_command_table();
        bit full, br;
        logic [7:0] on, off, r, g, b;
        int nw;
        for (int t = 0; t < 12; t++) begin
            full = 1'($urandom_range(0, 1));  br = 1'($urandom_range(0, 1));
            on = pick8();  off = pick8();  r = pick8();  g = pick8();  b = pick8();
            if (t == 0) begin
                full = 1; br = 1; on = 8'h19; off = 8'h19; r = 8'h40; g = 8'h80; b = 8'hC0;
            end else if (t == 1) begin
                full = 0; r = 8'h11; g = 8'h22; b = 8'h33;
            end else if (t == 2) begin
                full = 1; br = 0;
            end
            exp_q.delete();
            model_cmd(full, br, on, off, r, g, b);
            nw = exp_q.size();
            n_cmp++;
            if (cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL cmd%0d_ready_before: got %b want 1", t, cmd_ready);
            end
            send_capture(full, br, on, off, r, g, b, nw + 2);
            for (int k = 1; k <= nw; k++) begin
                n_cmp++;
                if (rec_ctl[k] !== CTL_WRITE || rec_wr[k] !== exp_q[k-1]) begin
                    n_fail++;
                    $display("FAIL cmd%0d_write%0d: ctl=%b addr:dat=%h, want ctl=%b addr:dat=%h",
                             t, k, rec_ctl[k], rec_wr[k], CTL_WRITE, exp_q[k-1]);
                end
            end
            n_cmp++;
            if (rec_ctl[nw+1] !== CTL_FINISH) begin
                n_fail++;
                $display("FAIL cmd%0d_done: ctl=%b want %b", t, rec_ctl[nw+1], CTL_FINISH);
            end
            n_cmp++;
            if (rec_ctl[nw+2] !== CTL_READY) begin
                n_fail++;
                $display("FAIL cmd%0d_ready_after: ctl=%b want %b", t, rec_ctl[nw+2], CTL_READY);
            end
            model_cfg_ok = 1'b1;
        end
    endtask

    // cmd_valid held high with fields changing every cycle.
    task automatic test_back_to_back();
        int acc = -100, nw = 0, next_acc = 0, accepts = 0;
        bit finished = 0;
        bit exp_rdy, exp_done, exp_wr;
        logic [11:0] w;
        exp_q.delete();
        for (int e = 0; e < 200; e++) begin
            cmd_valid = (accepts < 4);
            scramble();
            @(posedge clk);
            if (cmd_valid && e == next_acc) begin
                model_cmd(cmd_full, cmd_breathe, cmd_on_time, cmd_off_time,
                          cmd_pwm_r, cmd_pwm_g, cmd_pwm_b);
                nw = exp_q.size();
                acc = e;
                next_acc = e + nw + 2;
                accepts++;
            end
            @(negedge clk);
            exp_rdy  = !(e >= acc && e <= acc + nw);
            exp_done = (e == acc + nw);
            exp_wr   = (e >= acc && e < acc + nw);
            n_cmp++;
            if ({cmd_ready, done, ledd_cs, ledd_den, ledd_exe} !==
                {exp_rdy, exp_done, exp_wr, exp_wr, !exp_wr}) begin
                n_fail++;
                $display("FAIL b2b_ctl[%0d]: rdy/done/cs/den/exe=%b, want %b", e,
                         {cmd_ready, done, ledd_cs, ledd_den, ledd_exe},
                         {exp_rdy, exp_done, exp_wr, exp_wr, !exp_wr});
            end
            if (exp_wr) begin
                w = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hFFF;
                n_cmp++;
                if ({ledd_addr, ledd_dat} !== w) begin
                    n_fail++;
                    $display("FAIL b2b_write[%0d]: addr:dat=%h want %h", e,
                             {ledd_addr, ledd_dat}, w);
                end
            end
            if (accepts == 4 && e == acc + nw + 1) begin
                finished = 1;
                break;
            end
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (!finished || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_complete: finished=%0d leftover=%0d, want 1 and 0",
                     finished, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] on, off, r, g, b;
        on = pick8();  off = pick8();  r = pick8();  g = pick8();  b = pick8();
        exp_q.delete();
        model_cmd(1'b1, 1'b1, on, off, r, g, b);
        send_capture(1'b1, 1'b1, on, off, r, g, b, 5);
        n_cmp++;
        if (rec_ctl[5] !== CTL_WRITE || rec_wr[5] !== exp_q[4]) begin
            n_fail++;
            $display("FAIL mid_write5: ctl=%b addr:dat=%h, want ctl=%b addr:dat=%h",
                     rec_ctl[5], rec_wr[5], CTL_WRITE, exp_q[4]);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_ready, busy, done, ledd_cs, ledd_den, ledd_exe} !== CTL_RESET ||
            {ledd_addr, ledd_dat} !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_async_reset: ctl=%b addr:dat=%h, want ctl=%b addr:dat=000",
                     {cmd_ready, busy, done, ledd_cs, ledd_den, ledd_exe},
                     {ledd_addr, ledd_dat}, CTL_RESET);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_cfg_ok = 1'b0;
        // PWM-only request right after reset must still write all registers.
        on = pick8();  off = pick8();  r = pick8();  g = pick8();  b = pick8();
        exp_q.delete();
        model_cmd(1'b0, 1'b0, on, off, r, g, b);
        send_capture(1'b0, 1'b0, on, off, r, g, b, 11);
        n_cmp++;
        if (exp_q.size() != 9) begin
            n_fail++;
            $display("FAIL post_reset_len: model gives %0d writes, want 9", exp_q.size());
        end
        for (int k = 1; k <= 9; k++) begin
            n_cmp++;
            if (rec_ctl[k] !== CTL_WRITE || rec_wr[k] !== exp_q[k-1]) begin
                n_fail++;
                $display("FAIL post_reset_write%0d: ctl=%b addr:dat=%h, want ctl=%b addr:dat=%h",
                         k, rec_ctl[k], rec_wr[k], CTL_WRITE, exp_q[k-1]);
            end
        end
        n_cmp++;
        if (rec_ctl[10] !== CTL_FINISH || rec_ctl[11] !== CTL_READY) begin
            n_fail++;
            $display("FAIL post_reset_finish: ctl=%b,%b want %b,%b",
                     rec_ctl[10], rec_ctl[11], CTL_FINISH, CTL_READY);
        end
        model_cfg_ok = 1'b1;
    endtask

    initial begin
        test_reset();
        test_command_table();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
